// File: rtl/alu_acc_unit.sv
// alu_acc_unit: WIDTH-bit accumulator ALU with carry/zero flags and a shift-add multiply
module alu_acc_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] in_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out_result,
  output logic             carry,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, mplier;
  logic [2*WIDTH-1:0] mcand, prod, prod_next;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] ext;
  assign ready = state == IDLE;
  assign out_result = acc;
  // single-cycle ALU result extended by one bit; the top bit becomes the new carry
  always_comb begin
    ext = '0;
    case (op_code)
      3'd0: ext = {1'b0, acc} + {1'b0, in_b};
      3'd1: ext = {1'b0, acc} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry};
      3'd2: ext = {1'b0, acc} - {1'b0, in_b};
      3'd3: ext = {1'b0, acc & in_b};
      3'd4: ext = {1'b0, acc | in_b};
      3'd5: ext = {1'b0, acc ^ in_b};
      default: ext = {carry, in_b};
    endcase
  end
  // partial product after adding the current multiplier bit
  always_comb prod_next = prod + (mplier[0] ? mcand : '0);
  // accept ops while idle; step the multiply one bit per cycle while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      carry <= 1'b0;
      zero <= 1'b1;
      done <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && op_code == 3'd7) begin
          mcand <= {{WIDTH{1'b0}}, acc};
          mplier <= in_b;
          prod <= '0;
          cnt <= '0;
          state <= MUL;
        end else if (start) begin
          acc <= ext[WIDTH-1:0];
          carry <= ext[WIDTH];
          zero <= ext[WIDTH-1:0] == '0;
          done <= 1'b1;
        end
      end else begin
        prod <= prod_next;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          acc <= prod_next[WIDTH-1:0];
          carry <= |prod_next[2*WIDTH-1:WIDTH];
          zero <= prod_next[WIDTH-1:0] == '0;
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_acc_unit.sv
// tb_alu_acc_unit: scoreboard bench for alu_acc_unit at WIDTH 4, 8 and 16
module tb_alu_acc_unit;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] op_code;
  logic s4, s8, s16;
  logic [3:0] in_b4;
  logic [7:0] in_b8;
  logic [15:0] in_b16;
  logic ready4, done4, carry4, zero4;
  logic ready8, done8, carry8, zero8;
  logic ready16, done16, carry16, zero16;
  logic [3:0] res4;
  logic [7:0] res8;
  logic [15:0] res16;
  logic [17:0] q4[$], q8[$], q16[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  alu_acc_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(s4), .op_code(op_code), .in_b(in_b4),
    .ready(ready4), .done(done4), .out_result(res4), .carry(carry4), .zero(zero4));
  alu_acc_unit #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .start(s8), .op_code(op_code), .in_b(in_b8),
    .ready(ready8), .done(done8), .out_result(res8), .carry(carry8), .zero(zero8));
  alu_acc_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .start(s16), .op_code(op_code), .in_b(in_b16),
    .ready(ready16), .done(done16), .out_result(res16), .carry(carry16), .zero(zero16));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic pop_chk(input string name, inout logic [17:0] q[$], input logic [17:0] got);
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected done got=%0h expected=none", name, got);
    end else chk(name, 32'(got), 32'(q.pop_front()));
  endtask
  always @(negedge clk) if (done4 === 1'b1) pop_chk("w4_result", q4, {zero4, carry4, 12'd0, res4});
  always @(negedge clk) if (done8 === 1'b1) pop_chk("w8_result", q8, {zero8, carry8, 8'd0, res8});
  always @(negedge clk) if (done16 === 1'b1) pop_chk("w16_result", q16, {zero16, carry16, res16});
  task automatic issue(input int d, input logic [2:0] op, input logic [15:0] b);
    op_code = op;
    in_b4 = b[3:0];
    in_b8 = b[7:0];
    in_b16 = b;
    s4 = d == 4;
    s8 = d == 8;
    s16 = d == 16;
    @(negedge clk);
    s4 = 1'b0;
    s8 = 1'b0;
    s16 = 1'b0;
  endtask
  task automatic wait_ready(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = d == 4 ? ready4 : d == 8 ? ready8 : ready16;
    end
    chk("ready_timeout", 32'(ok), 32'd1);
  endtask
  initial begin
    rst = 1'b1;
    s4 = 1'b0;
    s8 = 1'b0;
    s16 = 1'b0;
    op_code = '0;
    in_b4 = '0;
    in_b8 = '0;
    in_b16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_result", 32'(res8), 32'd0);
    chk("rst_flags", {30'd0, zero8, carry8}, 32'b10);
    chk("rst_ready_done", {30'd0, ready8, done8}, 32'b10);
    q8.push_back({1'b0, 1'b0, 16'd200}); issue(8, 3'd6, 16'd200);
    q8.push_back({1'b0, 1'b1, 16'd44});  issue(8, 3'd0, 16'd100);
    chk("add_ready", 32'(ready8), 32'd1);
    q8.push_back({1'b0, 1'b0, 16'd45});  issue(8, 3'd1, 16'd0);
    q8.push_back({1'b1, 1'b0, 16'd0});   issue(8, 3'd2, 16'd45);
    q8.push_back({1'b0, 1'b0, 16'd5});   issue(8, 3'd6, 16'd5);
    q8.push_back({1'b0, 1'b1, 16'd251}); issue(8, 3'd2, 16'd10);
    q8.push_back({1'b1, 1'b0, 16'd0});   issue(8, 3'd5, 16'd251);
    q8.push_back({1'b0, 1'b0, 16'd20});  issue(8, 3'd6, 16'd20);
    q8.push_back({1'b0, 1'b1, 16'd4});   issue(8, 3'd7, 16'd13);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", {23'd0, ready8, res8}, {23'd0, 1'b0, 8'd20});
      s8 = i == 2;
      op_code = i == 2 ? 3'd6 : 3'd7;
      in_b8 = 8'd99;
      @(negedge clk);
    end
    s8 = 1'b0;
    chk("mul_done", {22'd0, done8, ready8, res8}, {22'd0, 1'b1, 1'b1, 8'd4});
    @(negedge clk);
    chk("mul_done_pulse", {23'd0, done8, res8}, {23'd0, 1'b0, 8'd4});
    issue(8, 3'd7, 16'd5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {20'd0, ready8, done8, zero8, carry8, res8}, {20'd0, 4'b1010, 8'd0});
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(q8.size()), 32'd0);
    q4.push_back({1'b0, 1'b0, 16'd15}); issue(4, 3'd6, 16'd15);
    q4.push_back({1'b0, 1'b1, 16'd1});  issue(4, 3'd7, 16'd15);
    chk("w4_busy", 32'(ready4), 32'd0);
    wait_ready(4);
    chk("w4_final", {27'd0, carry4, res4}, {27'd0, 1'b1, 4'd1});
    q16.push_back({1'b0, 1'b0, 16'd300});   issue(16, 3'd6, 16'd300);
    q16.push_back({1'b0, 1'b0, 16'd60000}); issue(16, 3'd7, 16'd200);
    chk("w16_busy", 32'(ready16), 32'd0);
    wait_ready(16);
    chk("w16_final", {15'd0, carry16, res16}, {15'd0, 1'b0, 16'd60000});
    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(q4.size() + q8.size() + q16.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_acc_unit.md
# alu_acc_unit

Parametrised accumulator execution unit: successor to the 8-bit ALU + accumulator + carry-register operation block. It holds a WIDTH-bit accumulator, carry and zero flags, and executes one operation per `start` request against operand `in_b`. Single-cycle ALU ops and a multi-cycle shift-add multiply are supported, with a ready/done handshake. It sits between the control sequencer (which issues `op_code`/`start`) and the register/bus side (which supplies `in_b` and reads `out_result`).

## Interface
- `WIDTH`, 8, datapath/accumulator width in bits; legal values are ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: operation request; sampled only while `ready`=1.
- `op_code` input 3: operation select; sampled with `start`.
- `in_b` input WIDTH: second operand; sampled with `start`.
- `ready` output 1: unit idle, able to accept `start`.
- `done` output 1: one-cycle pulse, result and flags valid.
- `out_result` output WIDTH: accumulator contents.
- `carry` output 1: carry/borrow/overflow flag register.
- `zero` output 1: 1 when the last completed result is 0.

## Operation
- States: IDLE, MUL. `ready` = (state==IDLE).
- Accept: rising edge with `ready`=1 and `start`=1. Otherwise `start` is ignored; operands are not latched.
- op_code: 0 ADD acc+b, carry=carry-out. 1 ADC acc+b+carry, carry=carry-out. 2 SUB acc−b, carry=borrow (1 when b>acc unsigned). 3 AND. 4 OR. 5 XOR; 3–5 clear carry. 6 LOAD acc=b; carry unchanged. 7 MUL.
- Arithmetic is unsigned and mod 2^WIDTH. Carry is the WIDTH+1 bit of the extended sum/difference.
- Ops 0–6: acc, carry and zero update at the accept edge. State stays IDLE.
- MUL: at the accept edge, latch multiplicand=acc and multiplier=b. Clear the 2·WIDTH partial product and bit counter, then go to MUL.
  - Each MUL-state edge processes one multiplier bit, LSB first: add the shifted multiplicand if the bit is 1, then increment the counter.
  - On the WIDTH-th MUL edge: acc = product[WIDTH-1:0], carry = |product[2W-1:WIDTH], zero = (acc==0), return to IDLE.
  - acc/flags keep their pre-MUL values until that edge.
- zero is recomputed on every completed op, including LOAD.
- Reset: acc=0, carry=0, zero=1, state=IDLE, counter=0, done=0, ready=1. Reset during MUL aborts it; no `done` is produced.

## Timing
- Ops 0–6: accepted at edge k; `out_result`/flags are new after edge k; `done`=1 from edge k to edge k+1. `ready` stays 1, so back-to-back ops are allowed every cycle and `done` stays high continuously.
- MUL: accepted at edge k; `ready`=0 from edge k to edge k+WIDTH. Result is visible after edge k+WIDTH; `done`=1 for the cycle from edge k+WIDTH to edge k+WIDTH+1, with `ready`=1 in that same cycle. A new `start` there is accepted at edge k+WIDTH+1.
- Latency: 1 cycle for ops 0–6; WIDTH cycles for MUL.
- `rst` wins over `start` on the same edge. `done` is 0 in the cycle after a reset edge.
- `done` is registered; all outputs come directly from flops.

## Test plan
- Reset then ADD: rst 1 cycle; LOAD 200, ADD 100 -> out_result=44, carry=1, zero=0, done pulses after each edge, ready stays 1.
- ADC chain: after the previous test (carry=1), ADC in_b=0 -> out_result=45, carry=0. Then SUB 45 -> out_result=0, zero=1, carry=0.
- Borrow and logic: LOAD 5, SUB 10 -> out_result=251, carry=1. Then XOR 251 -> out_result=0, zero=1, carry=0.
- MUL, WIDTH=8: LOAD 20, MUL in_b=13 -> ready=0 for 8 cycles. out_result holds 20 until edge k+8, then becomes 4 with carry=1 (260). done is high exactly one cycle.
- Busy/abort: during MUL, pulse start with LOAD 99 -> ignored, result still 4. A second MUL with rst asserted at cycle 3 -> out_result=0, zero=1, ready=1, no done.
- Parameter sweep WIDTH=4 and 16: MUL 15×15 (W=4) -> out_result=1, carry=1 after 4 cycles. MUL 300×200 (W=16) -> out_result=60000, carry=0 after 16 cycles.
